// File: rtl/lisnoc_mp_simple_initiator_pkg.sv
// rtl/lisnoc_mp_simple_initiator_pkg.sv - flit types, endpoint addresses and FSM states for the MP initiator
package lisnoc_mp_simple_initiator_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    localparam logic [5:0] MP_ADDR_DATA       = 6'h00;
    localparam logic [5:0] MP_ADDR_OUT_EMPTY  = 6'h10;
    localparam logic [5:0] MP_ADDR_IN_WAITING = 6'h18;

    typedef enum logic [2:0] {
        IDLE,
        TX_SIZE,
        TX_FLIT,
        RX_SIZE,
        RX_FLIT
    } state_t;

    // Type of the idx-th flit of a received message of the given length.
    function automatic logic [1:0] rx_flit_type(input int unsigned idx, input int unsigned size);
        if (size == 1)
            return FLIT_SINGLE;
        else if (idx == 0)
            return FLIT_HEADER;
        else if (idx == size - 1)
            return FLIT_LAST;
        return FLIT_PAYLOAD;
    endfunction

endpackage

// File: rtl/lisnoc_mp_initiator_txbuf.sv
// rtl/lisnoc_mp_initiator_txbuf.sv - single-packet TX buffer with saturating count and overflow pulse
module lisnoc_mp_initiator_txbuf #(
    parameter int noc_data_width = 32,
    parameter int size_width     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [noc_data_width-1:0] data_in,
    input  logic                      last,
    input  logic                      valid,
    output logic                      ready,
    input  logic                      clear,
    input  logic [size_width-1:0]     rd_ptr,
    output logic [noc_data_width-1:0] rd_data,
    output logic [size_width-1:0]     count,
    output logic                      pkt_rdy,
    output logic                      overflow
);

    localparam int max_flits = 2**size_width - 1;
    localparam logic [size_width-1:0] full_count = size_width'(max_flits);

    logic [noc_data_width-1:0] mem [max_flits];
    logic                      accept;
    logic                      store;

    assign ready   = !pkt_rdy;
    assign accept  = valid && !pkt_rdy;
    assign store   = accept && (count != full_count);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (store)
            mem[count] <= data_in;
    end

    // A dropped flit still closes the packet if it carries the end marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            pkt_rdy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= accept && !store;
            if (clear) begin
                count   <= '0;
                pkt_rdy <= 1'b0;
            end else if (accept) begin
                if (store)
                    count <= count + 1'b1;
                if (last)
                    pkt_rdy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_mp_simple_initiator.sv
// rtl/lisnoc_mp_simple_initiator.sv - bus initiator moving flit streams through the simple MP endpoint
module lisnoc_mp_simple_initiator
    import lisnoc_mp_simple_initiator_pkg::*;
#(
    parameter int noc_data_width = 32,
    parameter int noc_type_width = 2,
    parameter int size_width     = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [noc_data_width+noc_type_width-1:0] tx_flit,
    input  logic                                     tx_valid,
    output logic                                     tx_ready,
    output logic [noc_data_width+noc_type_width-1:0] rx_flit,
    output logic                                     rx_valid,
    input  logic                                     rx_ready,
    output logic                                     tx_overflow,
    output logic [5:0]                               bus_addr,
    output logic                                     bus_we,
    output logic                                     bus_en,
    output logic [noc_data_width-1:0]                bus_data_in,
    input  logic [noc_data_width-1:0]                bus_data_out,
    input  logic                                     bus_ack,
    input  logic                                     irq
);

    localparam int fw = noc_data_width + noc_type_width;

    state_t                    state, state_nxt;
    logic                      bus_en_nxt, bus_we_nxt;
    logic [noc_data_width-1:0] bus_data_in_nxt;
    logic [size_width-1:0]     rd_ptr, rd_ptr_nxt, rd_addr;
    logic [size_width-1:0]     rx_size, rx_size_nxt;
    logic [size_width-1:0]     rx_idx, rx_idx_nxt;
    logic [fw-1:0]             rx_flit_nxt;
    logic                      rx_valid_nxt;
    logic                      buf_clear;
    logic [noc_data_width-1:0] rd_data;
    logic [size_width-1:0]     count;
    logic                      pkt_rdy;
    logic                      ack;
    logic [size_width-1:0]     size_rd;
    logic                      unused_bits;

    assign unused_bits = ^{tx_flit[noc_data_width], bus_data_out[noc_data_width-1:size_width]};
    assign bus_addr    = MP_ADDR_DATA;
    assign ack         = bus_en && bus_ack;
    assign size_rd     = bus_data_out[size_width-1:0];

    lisnoc_mp_initiator_txbuf #(
        .noc_data_width(noc_data_width),
        .size_width    (size_width)
    ) u_txbuf (
        .clk     (clk),
        .rst     (rst),
        .data_in (tx_flit[noc_data_width-1:0]),
        .last    (tx_flit[noc_data_width+1]),
        .valid   (tx_valid),
        .ready   (tx_ready),
        .clear   (buf_clear),
        .rd_ptr  (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .pkt_rdy (pkt_rdy),
        .overflow(tx_overflow)
    );

    always_comb begin
        state_nxt       = state;
        bus_en_nxt      = bus_en;
        bus_we_nxt      = bus_we;
        bus_data_in_nxt = bus_data_in;
        rd_ptr_nxt      = rd_ptr;
        rx_size_nxt     = rx_size;
        rx_idx_nxt      = rx_idx;
        rx_flit_nxt     = rx_flit;
        rx_valid_nxt    = rx_valid && !rx_ready;
        buf_clear       = 1'b0;
        // Prefetch address: the word to present after the current ack.
        rd_addr         = (state == TX_SIZE) ? '0 : rd_ptr + 1'b1;

        case (state)
            IDLE: begin
                if (irq) begin
                    state_nxt       = RX_SIZE;
                    bus_en_nxt      = 1'b1;
                    bus_we_nxt      = 1'b0;
                    bus_data_in_nxt = '0;
                end else if (pkt_rdy) begin
                    state_nxt       = TX_SIZE;
                    bus_en_nxt      = 1'b1;
                    bus_we_nxt      = 1'b1;
                    bus_data_in_nxt = '0;
                    bus_data_in_nxt[size_width-1:0] = count;
                end
            end
            TX_SIZE: begin
                if (ack) begin
                    state_nxt       = TX_FLIT;
                    rd_ptr_nxt      = '0;
                    bus_data_in_nxt = rd_data;
                end
            end
            TX_FLIT: begin
                if (ack) begin
                    if (rd_ptr == count - 1'b1) begin
                        state_nxt       = IDLE;
                        bus_en_nxt      = 1'b0;
                        bus_we_nxt      = 1'b0;
                        bus_data_in_nxt = '0;
                        buf_clear       = 1'b1;
                    end else begin
                        rd_ptr_nxt      = rd_ptr + 1'b1;
                        bus_data_in_nxt = rd_data;
                    end
                end
            end
            RX_SIZE: begin
                if (ack) begin
                    rx_size_nxt = size_rd;
                    rx_idx_nxt  = '0;
                    if (size_rd == '0) begin
                        state_nxt  = IDLE;
                        bus_en_nxt = 1'b0;
                    end else begin
                        state_nxt  = RX_FLIT;
                        bus_en_nxt = !rx_valid_nxt;
                    end
                end
            end
            RX_FLIT: begin
                if (ack) begin
                    rx_valid_nxt = 1'b1;
                    rx_flit_nxt  = '0;
                    rx_flit_nxt[noc_data_width +: 2] = rx_flit_type(32'(rx_idx), 32'(rx_size));
                    rx_flit_nxt[noc_data_width-1:0]  = bus_data_out;
                    bus_en_nxt   = 1'b0;
                    if (rx_idx == rx_size - 1'b1)
                        state_nxt = IDLE;
                    else
                        rx_idx_nxt = rx_idx + 1'b1;
                end else begin
                    // Hold off the next read until the consumer has taken the held flit.
                    bus_en_nxt = !rx_valid_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_en      <= 1'b0;
            bus_we      <= 1'b0;
            bus_data_in <= '0;
            rd_ptr      <= '0;
            rx_size     <= '0;
            rx_idx      <= '0;
            rx_flit     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus_en      <= bus_en_nxt;
            bus_we      <= bus_we_nxt;
            bus_data_in <= bus_data_in_nxt;
            rd_ptr      <= rd_ptr_nxt;
            rx_size     <= rx_size_nxt;
            rx_idx      <= rx_idx_nxt;
            rx_flit     <= rx_flit_nxt;
            rx_valid    <= rx_valid_nxt;
        end
    end

endmodule

// File: tb/tb_lisnoc_mp_simple_initiator.sv
// tb/tb_lisnoc_mp_simple_initiator.sv - self-checking bench with endpoint model and packet-level reference
module tb_lisnoc_mp_simple_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] tx_flit;
    logic        tx_valid;
    logic        tx_ready;
    logic [33:0] rx_flit;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        tx_overflow;
    logic [5:0]  bus_addr;
    logic        bus_we;
    logic        bus_en;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_ack;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Endpoint model state
    logic [31:0] rd_mem [0:2047];
    bit          is_size [0:2047];
    int          rd_pos = 0;
    int          rd_len = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    bit          noise_en = 0;
    logic        noise = 1'b0;
    int          rx_mode = 0;
    bit          pend = 0, fire = 0, fire_rd = 0, en_s = 0;
    logic        h_we;
    logic [31:0] h_data;

    logic [31:0] wr_log[$];
    logic [31:0] exp_wr[$];
    logic [33:0] rx_log[$];
    logic [33:0] exp_rx[$];
    logic [32:0] bus_log[$];
    int          ovf_cnt = 0;
    int          exp_ovf = 0;
    int          wr_chk = 0;
    int          rx_chk = 0;

    typedef struct {
        int          len;
        logic [31:0] base;
        int          delay;
        int          exp_size;
        int          exp_ovf;
    } tx_vec_t;

    lisnoc_mp_simple_initiator dut (
        .clk         (clk),
        .rst         (rst),
        .tx_flit     (tx_flit),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_flit     (rx_flit),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_overflow (tx_overflow),
        .bus_addr    (bus_addr),
        .bus_we      (bus_we),
        .bus_en      (bus_en),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .bus_ack     (bus_ack),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    assign bus_ack      = bus_en ? (wcnt >= ack_delay) : noise;
    assign bus_data_out = rd_mem[rd_pos];
    assign irq          = (rd_pos != rd_len);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_type(input int i, input int s);
        if (s == 1) return 2'b11;
        if (i == 0) return 2'b01;
        if (i == s - 1) return 2'b10;
        return 2'b00;
    endfunction

    // Monitor: transactions are decided at the negedge before the completing posedge.
    always @(negedge clk) begin
        if (rst) begin
            pend = 0; fire = 0; fire_rd = 0; en_s = 0;
        end else begin
            if (pend) begin
                chk("bus_hold_en", 64'(bus_en), 64'd1);
                chk("bus_hold_we", 64'(bus_we), 64'(h_we));
                chk("bus_hold_data", 64'(bus_data_in), 64'(h_data));
            end
            pend   = bus_en && !bus_ack;
            h_we   = bus_we;
            h_data = bus_data_in;
            fire   = bus_en && bus_ack;
            fire_rd = fire && !bus_we;
            en_s   = bus_en;
            if (fire) begin
                chk("bus_addr", 64'(bus_addr), 64'd0);
                bus_log.push_back({bus_we, bus_we ? bus_data_in : bus_data_out});
                if (bus_we)
                    wr_log.push_back(bus_data_in);
                else
                    chk("read_while_rx_valid", 64'(is_size[rd_pos] || !rx_valid), 64'd1);
            end
            if (rx_valid && rx_ready)
                rx_log.push_back(rx_flit);
            if (tx_overflow)
                ovf_cnt++;
        end
    end

    always @(posedge clk) begin
        if (fire_rd)
            rd_pos <= rd_pos + 1;
        wcnt  <= fire ? 0 : (en_s ? wcnt + 1 : 0);
        noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(posedge clk) begin
        #2;
        case (rx_mode)
            0:       rx_ready = 1'b1;
            1:       rx_ready = 1'($urandom_range(0, 1));
            default: rx_ready = ~rx_ready;
        endcase
    end

    task automatic push_rx(input int s, input logic [31:0] base);
        int p;
        p = rd_len;
        rd_mem[p]  = 32'(s);
        is_size[p] = 1;
        for (int i = 0; i < s; i++) begin
            rd_mem[p+1+i]  = base + 32'(i);
            is_size[p+1+i] = 0;
            exp_rx.push_back({exp_type(i, s), base + 32'(i)});
        end
        rd_len = p + s + 1;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input bit irq_last,
                            input int rs, input logic [31:0] rbase);
        int n, cnt;
        logic [1:0] ty;
        n = (len > 15) ? 15 : len;
        exp_wr.push_back(32'(n));
        for (int i = 0; i < n; i++) exp_wr.push_back(base + 32'(i));
        exp_ovf += (len > 15) ? len - 15 : 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ty = (len == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b00;
            tx_flit  = {ty, base + 32'(i)};
            tx_valid = 1'b1;
            if (irq_last && i == len - 1) push_rx(rs, rbase);
            cnt = 0;
            while (!tx_ready && cnt < 2000) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 2000) chk("tx_accept_timeout", 64'(cnt), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cnt = 0;
        while ((wr_log.size() < exp_wr.size() || rx_log.size() < exp_rx.size() ||
                rd_pos != rd_len || !tx_ready) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 3000) chk("done_timeout", 64'(cnt), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_logs();
        int n;
        chk("wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = wr_chk; i < n; i++)
            chk($sformatf("wr_data[%0d]", i), 64'(wr_log[i]), 64'(exp_wr[i]));
        wr_chk = n;
        chk("rx_count", 64'(rx_log.size()), 64'(exp_rx.size()));
        n = (rx_log.size() < exp_rx.size()) ? rx_log.size() : exp_rx.size();
        for (int i = rx_chk; i < n; i++)
            chk($sformatf("rx_flit[%0d]", i), 64'(rx_log[i]), 64'(exp_rx[i]));
        rx_chk = n;
        chk("ovf_count", 64'(ovf_cnt), 64'(exp_ovf));
        chk("bus_idle_en", 64'(bus_en), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        tx_vec_t vecs[5];
        logic [1:0] rx_types[4];
        int w0, o0, r0, b0, cnt, op, len, s;
        logic [31:0] base;

        vecs[0] = '{1,  32'hCAFE0001, 0, 1,  0};
        vecs[1] = '{3,  32'h0000000A, 2, 3,  0};
        vecs[2] = '{15, 32'h00000100, 1, 15, 0};
        vecs[3] = '{16, 32'h00000200, 0, 15, 1};
        vecs[4] = '{17, 32'h00000300, 1, 15, 2};
        rx_types = '{2'b01, 2'b00, 2'b00, 2'b10};

        rst = 1'b1; tx_valid = 1'b0; tx_flit = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 64'(tx_ready), 64'd1);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_rx_flit", 64'(rx_flit), 64'd0);
        chk("rst_tx_overflow", 64'(tx_overflow), 64'd0);
        chk("rst_bus_en", 64'(bus_en), 64'd0);
        chk("rst_bus_we", 64'(bus_we), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_data_in", 64'(bus_data_in), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven TX packets, including both overflow boundaries
        for (int v = 0; v < 5; v++) begin
            ack_delay = vecs[v].delay;
            w0 = wr_log.size();
            o0 = ovf_cnt;
            send_pkt(vecs[v].len, vecs[v].base, 0, 0, 0);
            chk("tx_ready_low_pending", 64'(tx_ready), 64'd0);
            wait_done();
            chk("vec_size", 64'((wr_log.size() > w0) ? wr_log[w0] : 32'hFFFFFFFF), 64'(vecs[v].exp_size));
            chk("vec_ovf", 64'(ovf_cnt - o0), 64'(vecs[v].exp_ovf));
            chk("tx_ready_after", 64'(tx_ready), 64'd1);
            compare_logs();
        end

        // RX 4 flits with toggling consumer and idle-time ack noise
        rx_mode = 2; ack_delay = 1; noise_en = 1;
        r0 = rx_log.size();
        push_rx(4, 32'h10);
        wait_done();
        for (int i = 0; i < 4; i++)
            if (rx_log.size() > r0 + i)
                chk($sformatf("rx4_type[%0d]", i), 64'(rx_log[r0+i][33:32]), 64'(rx_types[i]));
        compare_logs();

        // irq together with TX packet completion: RX must be served first
        rx_mode = 0; ack_delay = 0;
        b0 = bus_log.size();
        send_pkt(2, 32'h500, 1, 3, 32'h600);
        chk("tx_waits_for_rx", 64'(tx_ready), 64'd0);
        wait_done();
        chk("order_count", 64'(bus_log.size() - b0), 64'd7);
        for (int i = 0; i < 7; i++)
            if (bus_log.size() > b0 + i)
                chk($sformatf("order_we[%0d]", i), 64'(bus_log[b0+i][32]), (i < 4) ? 64'd0 : 64'd1);
        compare_logs();

        // Reset in the middle of RX_FLIT
        ack_delay = 1;
        r0 = rx_log.size();
        push_rx(6, 32'h700);
        cnt = 0;
        while (rx_log.size() < r0 + 2 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) chk("rx_progress_timeout", 64'(cnt), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_bus_en", 64'(bus_en), 64'd0);
        chk("async_rst_rx_valid", 64'(rx_valid), 64'd0);
        repeat (2) @(negedge clk);
        rd_len = rd_pos;
        while (exp_rx.size() > rx_log.size()) void'(exp_rx.pop_back());
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_bus_en", 64'(bus_en), 64'd0);
        chk("post_rst_tx_ready", 64'(tx_ready), 64'd1);
        send_pkt(2, 32'h800, 0, 0, 0);
        wait_done();
        compare_logs();

        // Randomized traffic against the packet-level model
        rx_mode = 1;
        for (int it = 0; it < 25; it++) begin
            ack_delay = $urandom_range(0, 3);
            op   = $urandom_range(0, 2);
            len  = $urandom_range(1, 18);
            s    = $urandom_range(0, 15);
            base = $urandom;
            if (op == 1)
                push_rx(s, base);
            else
                send_pkt(len, base, op == 2, s, base ^ 32'h5A5A0000);
            wait_done();
            compare_logs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
